fast_tcm_loader: RTL
====================

# fast_tcm_loader

Parametrised FAST-packet generator that streams a host-loaded program image into the CPU's ITCM/DTCM over the 134-bit FAST packet bus, then optionally issues the CPU start packet. It sits between the host/testbench and the CPU packet ingress, in place of a fixed-image boot generator. It adds a writable image RAM, burst splitting across multiple packets, a programmable base address, sink backpressure, and return-packet counting.

## Interface
Parameters:
- DEPTH, 1024, image RAM depth in 32-bit words (power of two, ≥ 4).
- AW, $clog2(DEPTH), image address width.
- BURST, 256, maximum data words per configuration packet (1..DEPTH).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- img_we  in  1  image RAM write strobe; ignored while busy=1.
- img_addr  in  AW  image write word address.
- img_wdata  in  32  image write data.
- start  in  1  one-cycle start request; accepted only in IDLE.
- base_addr  in  32  TCM word address of image word 0; sampled on accepted start.
- word_cnt  in  AW+1  number of words to send (0..DEPTH); sampled on start; values > DEPTH clamp to DEPTH.
- run_after  in  1  when 1, send the CPU start packet after the last config packet; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the job completes.
- pkt_cnt  out  16  packets fully emitted in the current or last job; cleared on accepted start.
- data_in_valid  out  1  flit valid toward the CPU.
- data_in  out  134  flit: [133:132] tag (01 head, 11 body, 10 tail), [131:128] 0, [127:0] payload.
- data_in_ready  in  1  sink accepts the flit when valid && ready.
- data_out_valid  in  1  return flit valid from the CPU.
- data_out  in  134  return flit.
- ack_cnt  out  16  count of return tail flits (data_out_valid && data_out[133:132]==2'b10); saturates at 16'hFFFF; cleared on accepted start.

## Operation
- Image RAM: DEPTH×32, synchronous write, synchronous read with 1-cycle latency. Contents are not reset.
- Configuration packet (the remaining word count is rem; n = min(BURST, rem)):
  - head {01, 0, 128'd0};
  - flit0 {11, 0, 128'd0};
  - type flit {11, 0, 96'd0, 16'h9003, 16'd0};
  - n data flits {tag, 0, 48'd0, img[i], base_addr+i, 16'd0}, with i the global word index;
  - the last data flit has tag 10, all others tag 11.
- Address arithmetic is mod 2^32. Word index i runs 0..word_cnt−1.
- Start packet (run_after=1): head, flit0, type flit with 16'h9001, then tail {10, 0, 128'd0}.
- State machine:
  - IDLE: on start, sample inputs, clear counters, then go to HDR, or to DONE if the clamped word_cnt=0 and run_after=0, or to RUN_HDR if word_cnt=0 and run_after=1.
  - Configuration path: HDR → F0 → TYPE → DATA. DATA repeats until n words are sent.
  - After DATA, if rem>0 go to GAP → HDR. If rem=0 go to GAP → RUN_HDR when run_after=1, otherwise go to DONE.
  - Start path: RUN_HDR → RUN_F0 → RUN_TYPE → RUN_TAIL → DONE.
  - DONE: assert done for one cycle, then return to IDLE.
- Every state advance requires the current flit to be accepted (valid && ready). While valid && !ready, data_in and data_in_valid must hold stable.
- pkt_cnt increments on acceptance of each tail flit.
- ack_cnt counts independently in every state.
- start while busy is ignored. img_we while busy is dropped, and the RAM is not modified.

## Timing
- Reset values:
  - data_in_valid=0, data_in=0;
  - busy=0, done=0;
  - pkt_cnt=0, ack_cnt=0;
  - state IDLE.
- Resetn asserted mid-job aborts immediately. Outputs return to reset values; the image RAM is retained.
- Start sampled in cycle T. The head flit is valid in cycle T+1, and busy=1 in T+1.
- With data_in_ready held high:
  - a configuration packet of n words occupies exactly n+3 consecutive valid cycles, with no bubbles inside the packet (RAM read prefetched during TYPE);
  - exactly one invalid cycle (GAP) follows each configuration packet;
  - the start packet occupies 4 consecutive valid cycles.
- done pulses the cycle after the final tail is accepted, and busy drops in that same cycle.
- data_out_valid with a tail tag in cycle T gives ack_cnt updated in T+1. A return tail arriving in the same cycle as an accepted start counts toward the new job (the count starts at 1).

## Test plan
- Load img[k]=32'hA000_0000+k for k<8; start with base_addr=0x100, word_cnt=8, BURST=256, run_after=0, ready=1 → one packet of 11 flits. The type flit carries 9003. The data flits carry (0xA0000000,0x100)…(0xA0000007,0x107), and only the last has tag 10. pkt_cnt=1, done after 12 cycles.
- word_cnt=600, BURST=256 → three packets of 256/256/88 words (259/259/91 flits), each followed by one GAP cycle. Addresses are contiguous across packets. pkt_cnt=3.
- word_cnt=4, run_after=1 → config packet, one GAP, then the 4-flit 9001 start packet. pkt_cnt=2.
- Toggle data_in_ready pseudo-randomly (50%) during the 600-word job → the accepted flit sequence is identical to the ready=1 run, and data_in is stable while stalled.
- Pulse start and img_we while busy → no second job, image unchanged. word_cnt=0, run_after=0 → done in T+1 with no flits.
- Assert resetn low mid-DATA, then release and restart → clean restart from head, image intact. Three return tail flits → ack_cnt=3.

Source files
------------

// File: rtl/fast_tcm_loader.sv
// FAST packet loader: streams a host-loaded image into ITCM/DTCM
// as burst-split config packets, then optionally the CPU start packet.
module fast_tcm_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int BURST = 256
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          img_we,
  input  logic [AW-1:0] img_addr,
  input  logic [31:0]   img_wdata,
  input  logic          start,
  input  logic [31:0]   base_addr,
  input  logic [AW:0]   word_cnt,
  input  logic          run_after,
  output logic          busy,
  output logic          done,
  output logic [15:0]   pkt_cnt,
  output logic          data_in_valid,
  output logic [133:0]  data_in,
  input  logic          data_in_ready,
  input  logic          data_out_valid,
  input  logic [133:0]  data_out,
  output logic [15:0]   ack_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_F0, S_TYPE, S_DATA, S_GAP,
    S_RUN_HDR, S_RUN_F0, S_RUN_TYPE, S_RUN_TAIL, S_DONE
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_W = (AW+1)'(BURST);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   left_q, left_d;
  logic          run_q, run_d;
  logic [15:0]   pkt_q, pkt_d;
  logic [15:0]   ack_q, ack_d;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   rd_q;
  logic [AW-1:0] rd_addr;

  logic          acc, start_ok, ret_tail, last;
  logic [AW:0]   wc;
  logic          unused_ok;

  assign acc       = data_in_valid && data_in_ready;
  assign start_ok  = (state_q == S_IDLE) && start;
  assign ret_tail  = data_out_valid && (data_out[133:132] == 2'b10);
  assign last      = (left_q == ONE_W);
  assign wc        = (word_cnt > DEPTH_W) ? DEPTH_W : word_cnt;
  assign unused_ok = ^data_out[131:0];

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);
  assign pkt_cnt = pkt_q;
  assign ack_cnt = ack_q;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    rem_d         = rem_q;
    idx_d         = idx_q;
    left_d        = left_q;
    run_d         = run_q;
    pkt_d         = pkt_q;
    ack_d         = ack_q;
    data_in_valid = 1'b0;
    data_in       = '0;
    rd_addr       = idx_q[AW-1:0];

    if (start_ok) begin
      ack_d = ret_tail ? 16'd1 : 16'd0;
    end else if (ret_tail && (ack_q != 16'hFFFF)) begin
      ack_d = ack_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_addr;
          rem_d  = wc;
          idx_d  = '0;
          run_d  = run_after;
          pkt_d  = '0;
          if (wc != '0)     state_d = S_HDR;
          else if (run_after) state_d = S_RUN_HDR;
          else              state_d = S_DONE;
        end
      end
      S_HDR: begin
        data_in_valid = 1'b1;
        data_in       = {2'b01, 132'd0};
        if (acc) begin
          left_d  = (rem_q > BURST_W) ? BURST_W : rem_q;
          state_d = S_F0;
        end
      end
      S_F0: begin
        data_in_valid = 1'b1;
        data_in       = {2'b11, 132'd0};
        if (acc) state_d = S_TYPE;
      end
      S_TYPE: begin
        data_in_valid = 1'b1;
        data_in       = {2'b11, 4'd0, 96'd0, 16'h9003, 16'd0};
        if (acc) state_d = S_DATA;
      end
      S_DATA: begin
        data_in_valid = 1'b1;
        data_in       = {last ? 2'b10 : 2'b11, 4'd0, 48'd0,
                         rd_q, base_q + 32'(idx_q), 16'd0};
        if (acc) begin
          idx_d   = idx_q + ONE_W;
          rem_d   = rem_q - ONE_W;
          left_d  = left_q - ONE_W;
          // Fetch the next word now so the following flit has no bubble.
          rd_addr = idx_d[AW-1:0];
          if (last) begin
            pkt_d = pkt_q + 16'd1;
            if ((rem_q != ONE_W) || run_q) state_d = S_GAP;
            else                           state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        state_d = (rem_q != '0) ? S_HDR : S_RUN_HDR;
      end
      S_RUN_HDR: begin
        data_in_valid = 1'b1;
        data_in       = {2'b01, 132'd0};
        if (acc) state_d = S_RUN_F0;
      end
      S_RUN_F0: begin
        data_in_valid = 1'b1;
        data_in       = {2'b11, 132'd0};
        if (acc) state_d = S_RUN_TYPE;
      end
      S_RUN_TYPE: begin
        data_in_valid = 1'b1;
        data_in       = {2'b11, 4'd0, 96'd0, 16'h9001, 16'd0};
        if (acc) state_d = S_RUN_TAIL;
      end
      S_RUN_TAIL: begin
        data_in_valid = 1'b1;
        data_in       = {2'b10, 132'd0};
        if (acc) begin
          pkt_d   = pkt_q + 16'd1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      run_q   <= 1'b0;
      pkt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      run_q   <= run_d;
      pkt_q   <= pkt_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (img_we && !busy) mem_q[img_addr] <= img_wdata;
    rd_q <= mem_q[rd_addr];
  end

endmodule
